// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of N requester fifos into one registered valid/ready sink.
// Each grant lasts at most BURST words; the last grant is the rotation pointer.
module fifo_rr_arbiter #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  parameter  int BURST = 4,
  localparam int GW    = $clog2(N),
  localparam int CW    = $clog2(BURST + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N-1:0]       src_avail,
  input  logic [N*WIDTH-1:0] src_data,
  output logic [N-1:0]       src_strobe,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state;
  logic [CW-1:0] burst_cnt;
  logic [GW-1:0] pick;
  logic [GW-1:0] nxt;
  logic [GW-1:0] sel;
  logic          found;
  logic          start;
  logic          more;
  logic [WIDTH-1:0] word;

  // First requester after the pointer, wrapping modulo N
  always_comb begin
    found = 1'b0;
    pick  = '0;
    nxt   = '0;
    for (int k = 1; k <= N; k++) begin
      nxt = GW'((int'(grant_id) + k) % N);
      if (!found && src_avail[nxt]) begin
        found = 1'b1;
        pick  = nxt;
      end
    end
  end

  assign start = (state == IDLE) && enable && found;
  assign more  = (state == XFER) && out_valid && out_ready
              && (burst_cnt < CW'(BURST)) && src_avail[grant_id];
  assign sel   = start ? pick : grant_id;
  assign word  = src_data[int'(sel)*WIDTH +: WIDTH];

  // Fifo read_data is combinational, so the strobe and capture share a cycle
  always_comb begin
    src_strobe = '0;
    if (!reset && (start || more))
      src_strobe[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_id  <= GW'(N - 1);
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= XFER;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= word;
            grant_id  <= pick;
            burst_cnt <= CW'(1);
          end
        end
        XFER: begin
          if (more) begin
            out_data  <= word;
            burst_cnt <= burst_cnt + 1'b1;
          end else if (out_valid && out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
